// File: rtl/bcd_ex3_counter.sv
// Synchronous multi-decade BCD up/down counter with parallel load.
// Each decade's Excess-3 code is decoded straight from the count register.
module bcd_ex3_counter #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      up_dn,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_val,
  output logic [4*NUM_DIGITS-1:0]   bcd,
  output logic [4*NUM_DIGITS-1:0]   ex3,
  output logic                      tc,
  output logic                      rollover,
  output logic                      load_err
);

  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0] bcd_q, bcd_d;
  logic         rollover_q, rollover_d;
  logic         load_err_q, load_err_d;
  logic         all_nine, all_zero;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      all_nine = all_nine & (bcd_q[4*i +: 4] == 4'd9);
      all_zero = all_zero & (bcd_q[4*i +: 4] == 4'd0);
    end
  end

  assign tc = en & (up_dn ? all_nine : all_zero);

  always_comb begin : next_state
    logic       ripple;
    logic       load_ok;
    logic [3:0] dig;
    logic [W-1:0] count_val;

    bcd_d      = bcd_q;
    rollover_d = 1'b0;
    load_err_d = 1'b0;
    load_ok    = 1'b1;
    count_val  = bcd_q;
    dig        = 4'd0;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_ok = load_ok & (load_val[4*i +: 4] <= 4'd9);
    end

    // A decade steps only while every lower decade sits at its wrap value.
    ripple = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = bcd_q[4*i +: 4];
      if (ripple) begin
        if (up_dn) count_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        else       count_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      end
      ripple = ripple & (up_dn ? (dig == 4'd9) : (dig == 4'd0));
    end

    if (load) begin
      if (load_ok) bcd_d = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      bcd_d      = count_val;
      rollover_d = ripple;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q      <= '0;
      rollover_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      rollover_q <= rollover_d;
      load_err_q <= load_err_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_ex3
    assign ex3[4*g +: 4] = bcd_q[4*g +: 4] + 4'd3;
  end

  assign bcd      = bcd_q;
  assign rollover = rollover_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_ex3_counter.sv
// Directed bench for 1-, 2- and 4-decade counters driven in lockstep,
// checked against a decimal-integer model through a scoreboard queue.
module tb_bcd_ex3_counter;

  logic        clk = 1'b0;
  logic        rst, en, up_dn, load;
  logic [31:0] lv;

  logic [3:0]  bcd1, ex31;
  logic [7:0]  bcd2, ex32;
  logic [15:0] bcd4, ex34;
  logic        tc1, tc2, tc4, ro1, ro2, ro4, le1, le2, le4;

  always #5 clk = ~clk;

  bcd_ex3_counter #(.NUM_DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[3:0]),
    .bcd(bcd1), .ex3(ex31), .tc(tc1), .rollover(ro1), .load_err(le1));
  bcd_ex3_counter #(.NUM_DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[7:0]),
    .bcd(bcd2), .ex3(ex32), .tc(tc2), .rollover(ro2), .load_err(le2));
  bcd_ex3_counter #(.NUM_DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[15:0]),
    .bcd(bcd4), .ex3(ex34), .tc(tc4), .rollover(ro4), .load_err(le4));

  typedef struct {
    int          k;
    logic [31:0] bcd;
    logic [31:0] ex3;
    logic        roll;
    logic        lerr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mval[3];
  int   ndig[3] = '{1, 2, 4};
  bit   known = 1'b0;

  function automatic int pow10(int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(int v, int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] to_ex3(int v, int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'((v % 10) + 3);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic get(input int k, output logic [31:0] b, output logic [31:0] x,
                     output logic t, output logic ro, output logic le);
    case (k)
      0:       begin b = {28'd0, bcd1}; x = {28'd0, ex31}; t = tc1; ro = ro1; le = le1; end
      1:       begin b = {24'd0, bcd2}; x = {24'd0, ex32}; t = tc2; ro = ro2; le = le2; end
      default: begin b = {16'd0, bcd4}; x = {16'd0, ex34}; t = tc4; ro = ro4; le = le4; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus on all three counters, check tc before the
  // edge, then pop and compare the registered results after it.
  task automatic step(input string tag, input logic r, input logic l,
                      input logic [31:0] v, input logic e, input logic u);
    logic [31:0] b, x;
    logic        t, ro, le;
    exp_t        ex;
    rst = r; load = l; lv = v; en = e; up_dn = u;
    #1;
    for (int k = 0; k < 3; k++) begin
      int m = pow10(ndig[k]);
      int nv = mval[k];
      int lval = 0;
      bit ok = 1'b1;
      logic roll = 1'b0, lerr = 1'b0;
      get(k, b, x, t, ro, le);
      if (known)
        check($sformatf("%s d%0d tc", tag, ndig[k]), {31'd0, t},
              {31'd0, e & (u ? (mval[k] == m - 1) : (mval[k] == 0))});
      for (int i = ndig[k] - 1; i >= 0; i--) begin
        if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        lval = lval * 10 + int'(v[4*i +: 4]);
      end
      if (r) nv = 0;
      else if (l) begin
        if (ok) nv = lval;
        else    lerr = 1'b1;
      end else if (e) begin
        if (u) begin
          nv = (mval[k] + 1) % m;
          roll = (mval[k] == m - 1);
        end else begin
          nv = (mval[k] + m - 1) % m;
          roll = (mval[k] == 0);
        end
      end
      mval[k] = nv;
      sb.push_back('{k, to_bcd(nv, ndig[k]), to_ex3(nv, ndig[k]), roll, lerr});
    end
    if (r) known = 1'b1;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      ex = sb.pop_front();
      get(ex.k, b, x, t, ro, le);
      check($sformatf("%s d%0d bcd", tag, ndig[ex.k]), b, ex.bcd);
      check($sformatf("%s d%0d ex3", tag, ndig[ex.k]), x, ex.ex3);
      check($sformatf("%s d%0d rollover", tag, ndig[ex.k]), {31'd0, ro}, {31'd0, ex.roll});
      check($sformatf("%s d%0d load_err", tag, ndig[ex.k]), {31'd0, le}, {31'd0, ex.lerr});
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; lv = '0;
    mval = '{0, 0, 0};
    @(posedge clk);
    #1;

    step("reset", 1, 0, 0, 0, 1);
    step("reset", 1, 0, 0, 0, 1);

    for (int i = 0; i < 100; i++) step("count_up", 0, 0, 0, 1, 1);
    step("hold", 0, 0, 0, 0, 1);

    step("down_wrap", 0, 0, 0, 1, 0);
    step("down_next", 0, 0, 0, 1, 0);

    step("load_over_en", 0, 1, 32'h47, 1, 1);
    step("after_load", 0, 0, 0, 1, 1);

    step("load_25", 0, 1, 32'h25, 0, 1);
    step("bad_load_a5", 0, 1, 32'hA5, 1, 1);
    step("bad_load_3f", 0, 1, 32'h3F, 1, 0);
    step("hold", 0, 0, 0, 0, 1);

    step("load_9999", 0, 1, 32'h9999, 0, 1);
    step("rst_mid", 1, 1, 32'h12, 1, 1);

    step("load_0999", 0, 1, 32'h0999, 0, 1);
    step("up_carry", 0, 0, 0, 1, 1);
    step("load_9999", 0, 1, 32'h9999, 0, 1);
    step("up_wrap", 0, 0, 0, 1, 1);
    step("load_1000", 0, 1, 32'h1000, 0, 1);
    step("down_borrow", 0, 0, 0, 1, 0);

    for (int i = 0; i < 40; i++)
      step("random", 0, ($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
